// File: rtl/lsu_mmio_v2_if.sv
// Request/response bus between a core's load/store unit and lsu_mmio_v2.
interface lsu_mmio_v2_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_wren;
  logic [2:0]  i_type_access;
  logic [31:0] i_st_data;
  logic        o_rsp_valid;
  logic [31:0] o_ld_data;
  logic        o_misalign;

  modport slave (
    input  i_req_valid, i_lsu_addr, i_lsu_wren, i_type_access, i_st_data,
    output o_req_ready, o_rsp_valid, o_ld_data, o_misalign
  );

  modport master (
    output i_req_valid, i_lsu_addr, i_lsu_wren, i_type_access, i_st_data,
    input  o_req_ready, o_rsp_valid, o_ld_data, o_misalign
  );
endinterface

// File: rtl/lsu_mmio_v2.sv
// Load/store unit backend: word-organised data memory plus memory-mapped LEDs,
// seven-segment displays, LCD word and a synchronised switch input.
// One request is taken in IDLE, answered in the following RESP cycle.
module lsu_mmio_v2 #(
  parameter int unsigned DMEM_WORDS     = 512,
  parameter int unsigned SW_SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  lsu_mmio_v2_if.slave  bus,
  output logic [31:0]   o_io_ledr,
  output logic [31:0]   o_io_ledg,
  output logic [31:0]   o_io_lcd,
  output logic [6:0]    o_io_hex0,
  output logic [6:0]    o_io_hex1,
  output logic [6:0]    o_io_hex2,
  output logic [6:0]    o_io_hex3,
  output logic [6:0]    o_io_hex4,
  output logic [6:0]    o_io_hex5,
  output logic [6:0]    o_io_hex6,
  output logic [6:0]    o_io_hex7,
  input  logic [31:0]   i_io_sw
);

  localparam int unsigned IdxW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e state_q, state_d;

  logic [31:0] ld_data_q, ld_data_d;
  logic        misalign_q, misalign_d;
  logic [31:0] ledr_q, ledr_d;
  logic [31:0] ledg_q, ledg_d;
  logic [31:0] hexl_q, hexl_d;
  logic [31:0] hexh_q, hexh_d;
  logic [31:0] lcd_q, lcd_d;
  logic [31:0] sw_sync_q [SW_SYNC_STAGES];
  logic [31:0] sw_sync_d [SW_SYNC_STAGES];

  logic [31:0] dmem_q [DMEM_WORDS];

  // Address fields
  logic [19:0]     page;
  logic [9:0]      word_idx;
  logic [1:0]      boff;
  logic [IdxW-1:0] dmem_idx;

  assign page     = bus.i_lsu_addr[31:12];
  assign word_idx = bus.i_lsu_addr[11:2];
  assign boff     = bus.i_lsu_addr[1:0];
  assign dmem_idx = IdxW'(word_idx);

  // Region decode; peripheral pages alias every offset onto one register.
  logic hit_dmem, hit_ledr, hit_ledg, hit_hexl, hit_hexh, hit_lcd, hit_sw;

  assign hit_dmem = (page == 20'h00000) && ({22'd0, word_idx} < DMEM_WORDS);
  assign hit_ledr = (page == 20'h10000);
  assign hit_ledg = (page == 20'h10001);
  assign hit_hexl = (page == 20'h10002);
  assign hit_hexh = (page == 20'h10003);
  assign hit_lcd  = (page == 20'h10004);
  assign hit_sw   = (page == 20'h10010);

  // Access size decode; unlisted type codes behave as word accesses.
  logic is_byte, is_half, is_word, sign_ld, misalign;

  assign is_byte  = (bus.i_type_access == 3'b000) || (bus.i_type_access == 3'b100);
  assign is_half  = (bus.i_type_access == 3'b001) || (bus.i_type_access == 3'b101);
  assign is_word  = !is_byte && !is_half;
  assign sign_ld  = (bus.i_type_access == 3'b000) || (bus.i_type_access == 3'b001);
  assign misalign = (is_half && boff[0]) || (is_word && (boff != 2'b00));

  // Handshake; reset gating keeps a valid held during reset from touching memory.
  logic accept, do_store, dmem_we;

  assign accept   = (state_q == StIdle) && bus.i_req_valid && i_reset;
  assign do_store = accept && bus.i_lsu_wren && !misalign;
  assign dmem_we  = do_store && hit_dmem;

  // Byte-lane enables and store data replicated onto every lane.
  logic [3:0]  be;
  logic [31:0] wdata;

  always_comb begin
    be    = 4'b1111;
    wdata = bus.i_st_data;
    if (is_byte) begin
      be    = 4'b0001 << boff;
      wdata = {4{bus.i_st_data[7:0]}};
    end else if (is_half) begin
      be    = boff[1] ? 4'b1100 : 4'b0011;
      wdata = {2{bus.i_st_data[15:0]}};
    end
  end

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = lanes[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  // Read word select; unmapped regions read as zero.
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (hit_dmem)      rd_word = dmem_q[dmem_idx];
    else if (hit_ledr) rd_word = ledr_q;
    else if (hit_ledg) rd_word = ledg_q;
    else if (hit_hexl) rd_word = hexl_q;
    else if (hit_hexh) rd_word = hexh_q;
    else if (hit_lcd)  rd_word = lcd_q;
    else if (hit_sw)   rd_word = sw_sync_q[SW_SYNC_STAGES-1];
  end

  // Lane extraction and sign/zero extension of the load result.
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;

  always_comb begin
    unique case (boff)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half  = boff[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = rd_word;
    if (is_byte) begin
      load_val = {{24{sign_ld & rd_byte[7]}}, rd_byte};
    end else if (is_half) begin
      load_val = {{16{sign_ld & rd_half[15]}}, rd_half};
    end
  end

  // FSM next state: IDLE -> RESP on accept, RESP always back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Response capture on accept; held otherwise.
  always_comb begin
    ld_data_d  = ld_data_q;
    misalign_d = misalign_q;
    if (accept) begin
      misalign_d = misalign;
      ld_data_d  = (misalign || bus.i_lsu_wren) ? 32'd0 : load_val;
    end
  end

  // Peripheral register next state with lane-masked stores.
  always_comb begin
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    hexl_d = hexl_q;
    hexh_d = hexh_q;
    lcd_d  = lcd_q;
    if (do_store) begin
      if (hit_ledr) ledr_d = merge_lanes(ledr_q, wdata, be);
      if (hit_ledg) ledg_d = merge_lanes(ledg_q, wdata, be);
      if (hit_hexl) hexl_d = merge_lanes(hexl_q, wdata, be);
      if (hit_hexh) hexh_d = merge_lanes(hexh_q, wdata, be);
      if (hit_lcd)  lcd_d  = merge_lanes(lcd_q, wdata, be);
    end
  end

  // Switch synchroniser shift chain.
  always_comb begin
    sw_sync_d[0] = i_io_sw;
    for (int i = 1; i < SW_SYNC_STAGES; i++) begin
      sw_sync_d[i] = sw_sync_q[i-1];
    end
  end

  // State, response and peripheral registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      ld_data_q  <= '0;
      misalign_q <= 1'b0;
      ledr_q     <= '0;
      ledg_q     <= '0;
      hexl_q     <= '0;
      hexh_q     <= '0;
      lcd_q      <= '0;
      for (int i = 0; i < SW_SYNC_STAGES; i++) begin
        sw_sync_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ld_data_q  <= ld_data_d;
      misalign_q <= misalign_d;
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      hexl_q     <= hexl_d;
      hexh_q     <= hexh_d;
      lcd_q      <= lcd_d;
      for (int i = 0; i < SW_SYNC_STAGES; i++) begin
        sw_sync_q[i] <= sw_sync_d[i];
      end
    end
  end

  // Data memory: no reset, byte-lane write on the accept edge.
  always_ff @(posedge i_clk) begin
    if (dmem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) dmem_q[dmem_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign bus.o_req_ready = (state_q == StIdle);
  assign bus.o_rsp_valid = (state_q == StResp);
  assign bus.o_ld_data   = ld_data_q;
  assign bus.o_misalign  = misalign_q;

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;
  assign o_io_hex0 = hexl_q[6:0];
  assign o_io_hex1 = hexl_q[14:8];
  assign o_io_hex2 = hexl_q[22:16];
  assign o_io_hex3 = hexl_q[30:24];
  assign o_io_hex4 = hexh_q[6:0];
  assign o_io_hex5 = hexh_q[14:8];
  assign o_io_hex6 = hexh_q[22:16];
  assign o_io_hex7 = hexh_q[30:24];

endmodule
